sym_hist_expander: RTL and testbench

- Expands one 8-symbol histogram into a serial stream of 2-bit symbols.
- Input: a frame histogram of counts for symbols 00/01/10/11. Output: one symbol per accepted beat, in ascending symbol order, with a frame-last marker and the frame's majority symbol.
- It is the transmit-side counterpart of the combinational symbol counter/majority block. It regenerates a canonical symbol frame from the counts that block produces, for loopback checking and for feeding downstream serial stages.

---
 rtl/sym_pkg.sv | 35 +++
 rtl/sym_pick.sv | 31 +++
 rtl/sym_hist_expander.sv | 115 +++++++++++
 tb/tb_sym_hist_expander.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_pkg.sv
// rtl/sym_pkg.sv - shared symbol types, frame length, FSM states and mode tie-break
package sym_pkg;

    typedef logic [1:0] sym_t;

    localparam int FRAME_LEN  = 8;
    // Widest count the mode function accepts; narrower counts are zero-extended.
    localparam int MODE_CNT_W = 8;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Majority symbol; ties resolve to the lowest symbol index.
    function automatic sym_t mode_of(
        input logic [MODE_CNT_W-1:0] c0,
        input logic [MODE_CNT_W-1:0] c1,
        input logic [MODE_CNT_W-1:0] c2,
        input logic [MODE_CNT_W-1:0] c3
    );
        sym_t m;
        if (c0 >= c1 && c0 >= c2 && c0 >= c3) begin
            m = 2'd0;
        end else if (c1 >= c0 && c1 >= c2 && c1 >= c3) begin
            m = 2'd1;
        end else if (c2 >= c0 && c2 >= c1 && c2 >= c3) begin
            m = 2'd2;
        end else begin
            m = 2'd3;
        end
        return m;
    endfunction

endpackage

// File: rtl/sym_pick.sv
// rtl/sym_pick.sv - priority picker: lowest symbol with a nonzero remaining count
module sym_pick
    import sym_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] rem0,
    input  logic [W-1:0] rem1,
    input  logic [W-1:0] rem2,
    input  logic [W-1:0] rem3,
    output sym_t         idx,
    output logic         any
);

    // Lowest nonzero index wins so zero counts are skipped without bubbles.
    always_comb begin
        any = (rem0 != '0) || (rem1 != '0) || (rem2 != '0) || (rem3 != '0);
        if (rem0 != '0) begin
            idx = 2'd0;
        end else if (rem1 != '0) begin
            idx = 2'd1;
        end else if (rem2 != '0) begin
            idx = 2'd2;
        end else if (rem3 != '0) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
    end

endmodule

// File: rtl/sym_hist_expander.sv
// rtl/sym_hist_expander.sv - expands a symbol histogram into a serial symbol frame
module sym_hist_expander
    import sym_pkg::*;
#(
    parameter int FRAME = FRAME_LEN,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    input  logic [CNT_W-1:0] cnt2,
    input  logic [CNT_W-1:0] cnt3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_data,
    output logic             out_last,
    output logic [1:0]       frame_mode,
    output logic             err
);

    localparam int SUM_W = CNT_W + 2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q [4];
    logic [CNT_W-1:0] rem_d [4];
    sym_t             mode_q, mode_d;
    logic             err_q, err_d;

    logic [SUM_W-1:0] in_sum;
    logic [SUM_W-1:0] rem_sum;
    logic             sum_ok;
    sym_t             pick_idx;
    logic             pick_any;

    sym_pick #(.W(CNT_W)) u_pick (
        .rem0 (rem_q[0]),
        .rem1 (rem_q[1]),
        .rem2 (rem_q[2]),
        .rem3 (rem_q[3]),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Sums are widened so out-of-range counts cannot wrap into a false match.
    always_comb begin
        in_sum  = SUM_W'(cnt0) + SUM_W'(cnt1) + SUM_W'(cnt2) + SUM_W'(cnt3);
        sum_ok  = (in_sum == SUM_W'(FRAME));
        rem_sum = SUM_W'(rem_q[0]) + SUM_W'(rem_q[1]) + SUM_W'(rem_q[2]) + SUM_W'(rem_q[3]);
    end

    // Outputs depend only on state and rem registers, never on out_ready or in_valid.
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == EMIT) && pick_any;
        out_data   = pick_idx;
        out_last   = out_valid && (rem_sum == SUM_W'(1));
        frame_mode = mode_q;
        err        = err_q;
    end

    // Next-state: accept/reject histograms in IDLE, consume one symbol per beat in EMIT.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (sum_ok) begin
                        rem_d[0] = cnt0;
                        rem_d[1] = cnt1;
                        rem_d[2] = cnt2;
                        rem_d[3] = cnt3;
                        mode_d   = mode_of(MODE_CNT_W'(cnt0), MODE_CNT_W'(cnt1),
                                           MODE_CNT_W'(cnt2), MODE_CNT_W'(cnt3));
                        state_d  = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (!pick_any) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    rem_d[pick_idx] = rem_q[pick_idx] - CNT_W'(1);
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops out_valid immediately and discards the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '{default: '0};
            mode_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sym_hist_expander.sv
// tb/tb_sym_hist_expander.sv - scoreboard bench for sym_hist_expander
module tb_sym_hist_expander;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] cnt0 = '0;
    logic [3:0] cnt1 = '0;
    logic [3:0] cnt2 = '0;
    logic [3:0] cnt3 = '0;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_last;
    logic [1:0] frame_mode;
    logic       err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_n = 0;
    int acc_cyc = 0;
    int last_cyc = 0;
    int beats = 0;
    logic rand_rdy = 1'b0;
    logic prev_stall = 1'b0;
    logic [1:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic [2:0] sb_q[$];

    sym_hist_expander dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_mode (frame_mode),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_mode(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        int best;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        best = 0;
        for (int k = 1; k < 4; k++) if (c[k] > c[best]) best = k;
        return best[1:0];
    endfunction

    // Push the expected frame whenever a valid histogram is about to be accepted.
    always @(negedge clk) begin
        int c[4];
        int n;
        c[0] = int'(cnt0); c[1] = int'(cnt1); c[2] = int'(cnt2); c[3] = int'(cnt3);
        if (!rst && in_valid && in_ready && (c[0] + c[1] + c[2] + c[3] == 8)) begin
            n = 0;
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < c[k]; j++) begin
                    n++;
                    sb_q.push_back({k[1:0], (n == 8)});
                end
            end
            acc_n++;
            acc_cyc = cyc + 1;
        end
    end

    // Pop and compare each handshaken beat; check hold while stalled.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", 32'(out_data), 32'(prev_data));
                check_eq("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_beat", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("beat_data", 32'(out_data), 32'(e[2:1]));
                    check_eq("beat_last", 32'(out_last), 32'(e[0]));
                    beats++;
                    if (e[0]) last_cyc = cyc + 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int c0, input int c1, input int c2, input int c3);
        int n0;
        n0 = acc_n;
        cnt0 = 4'(c0); cnt1 = 4'(c1); cnt2 = 4'(c2); cnt3 = 4'(c3);
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (acc_n != n0) break;
        end
        in_valid = 1'b0;
        check_eq("accept_seen", 32'(acc_n), 32'(n0 + 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (in_ready && sb_q.size() == 0) break;
            tick();
        end
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
        check_eq("drain_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        int b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid2", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_frame_mode", 32'(frame_mode), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        tick();

        // {2,3,0,3} with out_ready held high
        out_ready = 1'b1;
        offer(2, 3, 0, 3);
        check_eq("t1_first_valid", 32'(out_valid), 32'd1);
        check_eq("t1_in_ready_low", 32'(in_ready), 32'd0);
        check_eq("t1_mode", 32'(frame_mode), 32'(exp_mode(2, 3, 0, 3)));
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("t1_frame_cycles", 32'(n), 32'd8);
        drain();

        offer(0, 0, 8, 0);
        check_eq("t2_mode", 32'(frame_mode), 32'(exp_mode(0, 0, 8, 0)));
        drain();

        // Bad sum {3,3,3,0}, held for two sampled edges
        n0 = acc_n;
        cnt0 = 4'd3; cnt1 = 4'd3; cnt2 = 4'd3; cnt3 = 4'd0;
        in_valid = 1'b1;
        tick();
        check_eq("bad_err", 32'(err), 32'd1);
        check_eq("bad_in_ready", 32'(in_ready), 32'd1);
        check_eq("bad_no_valid", 32'(out_valid), 32'd0);
        check_eq("bad_mode_kept", 32'(frame_mode), 32'(exp_mode(0, 0, 8, 0)));
        tick();
        check_eq("bad_err_held", 32'(err), 32'd1);
        in_valid = 1'b0;
        tick();
        check_eq("bad_err_clear", 32'(err), 32'd0);
        check_eq("bad_not_accepted", 32'(acc_n), 32'(n0));

        offer(2, 2, 2, 2);
        check_eq("t3_mode_tie", 32'(frame_mode), 32'(exp_mode(2, 2, 2, 2)));
        drain();

        // Random backpressure on {1,1,1,5}
        rand_rdy = 1'b1;
        offer(1, 1, 1, 5);
        check_eq("t4_mode", 32'(frame_mode), 32'(exp_mode(1, 1, 1, 5)));
        drain();
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        tick();

        // Reset after beat 3 of {4,4,0,0}
        b0 = beats;
        offer(4, 4, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (beats >= b0 + 3) break;
            tick();
        end
        check_eq("rst_mid_beats", 32'(beats - b0), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_last", 32'(out_last), 32'd0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_mid_idle", 32'(in_ready), 32'd1);
        check_eq("rst_mid_novalid", 32'(out_valid), 32'd0);
        tick();
        b0 = beats;
        offer(0, 0, 0, 8);
        check_eq("t5_mode", 32'(frame_mode), 32'(exp_mode(0, 0, 0, 8)));
        drain();
        check_eq("t5_beats", 32'(beats - b0), 32'd8);

        // Back-to-back with in_valid held
        tick();
        n0 = acc_n;
        cnt0 = 4'd2; cnt1 = 4'd3; cnt2 = 4'd0; cnt3 = 4'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (acc_n != n0) break;
        end
        cnt0 = 4'd1; cnt1 = 4'd1; cnt2 = 4'd1; cnt3 = 4'd5;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (acc_n >= n0 + 2) break;
        end
        in_valid = 1'b0;
        check_eq("b2b_accepts", 32'(acc_n), 32'(n0 + 2));
        check_eq("b2b_gap", 32'(acc_cyc - last_cyc), 32'd1);
        check_eq("b2b_mode", 32'(frame_mode), 32'(exp_mode(1, 1, 1, 5)));
        drain();

        check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
